fibo_engine: RTL and testbench

FIBO_ENGINE -- requirements
Module: fibo_engine

---
 rtl/fibo_pkg.sv | 23 ++
 rtl/fibo_datapath.sv | 53 +++++
 rtl/fibo_engine.sv | 127 ++++++++++++
 tb/tb_fibo_engine.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/fibo_pkg.sv
// Shared encodings for the Fibonacci/Lucas engine: FSM states, mode values
// and the per-mode seed constants.
package fibo_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      INIT = 2'd1,
      LOOP = 2'd2,
      FIN  = 2'd3
   } state_t;

   localparam logic MODE_FIB = 1'b0;
   localparam logic MODE_LUC = 1'b1;

   localparam int X0_FIB = 0;
   localparam int X0_LUC = 2;
   localparam int X1     = 1;

   function automatic int x0_of(input logic mode);
      return (mode == MODE_LUC) ? X0_LUC : X0_FIB;
   endfunction

endpackage

// File: rtl/fibo_datapath.sv
// Sequence registers A/B, down-counter CNT and the carry-producing adder.
// Sequenced entirely by the latch/init/step strobes from the controller.
module fibo_datapath
   import fibo_pkg::*;
#(
   parameter int W  = 8,
   parameter int NW = 6
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_latch,
   input  logic [NW-1:0] i_n,
   input  logic          i_init,
   input  logic [W-1:0]  i_x0,
   input  logic          i_step,
   output logic [W-1:0]  o_a,
   output logic          o_carry,
   output logic          o_cnt_zero,
   output logic          o_cnt_ge2
);

   logic [W-1:0]  r_a;
   logic [W-1:0]  r_b;
   logic [NW-1:0] r_cnt;
   logic [W:0]    w_sum;

   assign w_sum = {1'b0, r_a} + {1'b0, r_b};

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_a   <= '0;
         r_b   <= '0;
         r_cnt <= '0;
      end else begin
         if (i_latch)
            r_cnt <= i_n;
         if (i_init) begin
            r_a <= i_x0;
            r_b <= W'(X1);
         end else if (i_step) begin
            r_a   <= r_b;
            r_b   <= w_sum[W-1:0];
            r_cnt <= r_cnt - NW'(1);
         end
      end
   end

   assign o_a        = r_a;
   assign o_carry    = w_sum[W];
   assign o_cnt_zero = (r_cnt == '0);
   assign o_cnt_ge2  = (r_cnt > NW'(1));

endmodule

// File: rtl/fibo_engine.sv
// Iterative Fibonacci/Lucas generator: Moore controller driving fibo_datapath,
// with abort, saturating overflow flag and a one-cycle DONE pulse.
module fibo_engine
   import fibo_pkg::*;
#(
   parameter int W  = 8,
   parameter int NW = 6
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          START,
   input  logic          MODE,
   input  logic [NW-1:0] N,
   input  logic          ABORT,
   output logic          BUSY,
   output logic          DONE,
   output logic          OVF,
   output logic [W-1:0]  RESULT
);

   state_t       r_state;
   state_t       w_state_next;
   logic         r_mode;
   logic         r_ovf;
   logic [W-1:0] r_result;

   logic         w_latch;
   logic         w_init;
   logic         w_step;
   logic         w_res_load;
   logic         w_ovf_hit;
   logic [W-1:0] w_x0;
   logic [W-1:0] w_a;
   logic         w_carry;
   logic         w_cnt_zero;
   logic         w_cnt_ge2;

   assign w_x0 = W'(x0_of(r_mode));

   fibo_datapath #(.W(W), .NW(NW)) u_datapath (
      .i_clk      (CLK),
      .i_rst      (RST),
      .i_latch    (w_latch),
      .i_n        (N),
      .i_init     (w_init),
      .i_x0       (w_x0),
      .i_step     (w_step),
      .o_a        (w_a),
      .o_carry    (w_carry),
      .o_cnt_zero (w_cnt_zero),
      .o_cnt_ge2  (w_cnt_ge2)
   );

   always_ff @(posedge CLK or posedge RST) begin
      if (RST)
         r_state <= IDLE;
      else
         r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      w_latch      = 1'b0;
      w_init       = 1'b0;
      w_step       = 1'b0;
      w_res_load   = 1'b0;
      w_ovf_hit    = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (START && !ABORT) begin
               w_latch      = 1'b1;
               w_state_next = INIT;
            end
         end
         INIT: begin
            if (ABORT) begin
               w_state_next = IDLE;
            end else begin
               w_init       = 1'b1;
               w_state_next = LOOP;
            end
         end
         LOOP: begin
            if (ABORT) begin
               w_state_next = IDLE;
            end else if (w_cnt_zero) begin
               w_res_load   = 1'b1;
               w_state_next = FIN;
            end else begin
               w_step = 1'b1;
               // The final step's sum (CNT=1) is never consumed, so its carry is harmless
               if (w_carry && w_cnt_ge2) begin
                  w_ovf_hit    = 1'b1;
                  w_state_next = FIN;
               end
            end
         end
         FIN: w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_mode   <= MODE_FIB;
         r_ovf    <= 1'b0;
         r_result <= '0;
      end else begin
         if (w_latch) begin
            r_mode <= MODE;
            r_ovf  <= 1'b0;
         end
         if (w_ovf_hit) begin
            r_ovf    <= 1'b1;
            r_result <= '1;
         end else if (w_res_load) begin
            r_result <= w_a;
         end
      end
   end

   assign BUSY   = (r_state == INIT) || (r_state == LOOP);
   assign DONE   = (r_state == FIN);
   assign OVF    = r_ovf;
   assign RESULT = r_result;

endmodule

// File: tb/tb_fibo_engine.sv
// Directed self-checking bench for fibo_engine (W=8, NW=6) with
// hand-computed Fibonacci/Lucas results, latencies and control corner cases.
module tb_fibo_engine;

   localparam int W  = 8;
   localparam int NW = 6;

   logic          CLK;
   logic          RST;
   logic          START;
   logic          MODE;
   logic [NW-1:0] N;
   logic          ABORT;
   logic          BUSY;
   logic          DONE;
   logic          OVF;
   logic [W-1:0]  RESULT;

   int n_cmp;
   int n_err;

   fibo_engine #(.W(W), .NW(NW)) dut (
      .CLK    (CLK),
      .RST    (RST),
      .START  (START),
      .MODE   (MODE),
      .N      (N),
      .ABORT  (ABORT),
      .BUSY   (BUSY),
      .DONE   (DONE),
      .OVF    (OVF),
      .RESULT (RESULT)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check(input string tag, input int obs, input int exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Start one computation from the low clock phase and follow it to DONE.
   task automatic run(input string tag, input logic m, input int n,
                      input int exp_res, input int exp_ovf, input int exp_lat);
      int   cyc;
      logic seen;
      MODE  = m;
      N     = NW'(n);
      START = 1'b1;
      @(posedge CLK);
      #1 START = 1'b0;
      @(negedge CLK);
      check({tag, "_busy_init"}, int'(BUSY), 1);
      cyc  = 0;
      seen = 1'b0;
      while (!seen && cyc < 100) begin
         @(posedge CLK);
         cyc++;
         @(negedge CLK);
         if (DONE) seen = 1'b1;
      end
      check({tag, "_done_seen"}, int'(seen), 1);
      check({tag, "_latency"}, cyc, exp_lat);
      check({tag, "_result"}, int'(RESULT), exp_res);
      check({tag, "_ovf"}, int'(OVF), exp_ovf);
      check({tag, "_busy_fin"}, int'(BUSY), 0);
      $display("run %s mode=%0d n=%0d -> result=%0d ovf=%0d latency=%0d",
               tag, m, n, RESULT, OVF, cyc);
      @(negedge CLK);
      check({tag, "_done_pulse"}, int'(DONE), 0);
   endtask

   // Start Fib(10) then assert ABORT so it is sampled at edge k+d.
   task automatic abort_run(input string tag, input int d,
                            input int exp_res);
      logic seen;
      MODE  = 1'b0;
      N     = NW'(10);
      START = 1'b1;
      @(posedge CLK);
      #1 START = 1'b0;
      repeat (d - 1) @(posedge CLK);
      #1 ABORT = 1'b1;
      @(posedge CLK);
      #1 ABORT = 1'b0;
      @(negedge CLK);
      check({tag, "_busy"}, int'(BUSY), 0);
      check({tag, "_result"}, int'(RESULT), exp_res);
      check({tag, "_ovf"}, int'(OVF), 0);
      seen = 1'b0;
      repeat (15) begin
         @(negedge CLK);
         if (DONE) seen = 1'b1;
      end
      check({tag, "_no_done"}, int'(seen), 0);
      $display("abort %s at k+%0d -> result=%0d ovf=%0d", tag, d, RESULT, OVF);
   endtask

   initial begin
      int first_done;
      int second_done;
      int busy6;
      int busy7;
      n_cmp = 0;
      n_err = 0;
      RST   = 1'b1;
      START = 1'b0;
      MODE  = 1'b0;
      N     = '0;
      ABORT = 1'b0;
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      check("rst_busy", int'(BUSY), 0);
      check("rst_done", int'(DONE), 0);
      check("rst_result", int'(RESULT), 0);
      check("rst_ovf", int'(OVF), 0);
      RST = 1'b0;
      $display("reset released");

      run("fib10", 1'b0, 10, 55, 0, 12);
      run("luc0", 1'b1, 0, 2, 0, 2);
      run("fib0", 1'b0, 0, 0, 0, 2);
      run("fib1", 1'b0, 1, 1, 0, 3);
      run("luc11", 1'b1, 11, 199, 0, 13);
      run("fib13", 1'b0, 13, 233, 0, 15);
      run("fib14", 1'b0, 14, 255, 1, 14);
      run("luc12", 1'b1, 12, 255, 1, 12);

      // Abort after a clean run keeps 55; after an overflow keeps 255 but clears OVF
      run("fib10b", 1'b0, 10, 55, 0, 12);
      abort_run("abort_loop", 4, 55);
      run("luc12b", 1'b1, 12, 255, 1, 12);
      abort_run("abort_init", 1, 255);

      // ABORT together with START in IDLE blocks the start
      START = 1'b1;
      ABORT = 1'b1;
      @(posedge CLK);
      #1 START = 1'b0;
      ABORT = 1'b0;
      @(negedge CLK);
      check("abort_blocks_start", int'(BUSY), 0);
      $display("abort+start in idle -> busy=%0d", BUSY);

      // Asynchronous reset in the middle of LOOP
      run("fib10c", 1'b0, 10, 55, 0, 12);
      MODE  = 1'b0;
      N     = NW'(10);
      START = 1'b1;
      @(posedge CLK);
      #1 START = 1'b0;
      repeat (4) @(posedge CLK);
      @(negedge CLK);
      #1 RST = 1'b1;
      #1;
      check("arst_busy", int'(BUSY), 0);
      check("arst_result", int'(RESULT), 0);
      check("arst_ovf", int'(OVF), 0);
      check("arst_done", int'(DONE), 0);
      RST = 1'b0;
      #1;
      $display("async reset mid-loop -> busy=%0d result=%0d", BUSY, RESULT);
      run("fib5", 1'b0, 5, 5, 0, 7);

      // START held high: second run only after the idle edge following FIN
      first_done  = 0;
      second_done = 0;
      busy6       = -1;
      busy7       = -1;
      MODE  = 1'b0;
      N     = NW'(3);
      START = 1'b1;
      @(posedge CLK);
      for (int e = 1; e <= 12; e++) begin
         @(posedge CLK);
         @(negedge CLK);
         if (DONE) begin
            if (first_done == 0) first_done = e;
            else if (second_done == 0) second_done = e;
         end
         if (e == 6) busy6 = int'(BUSY);
         if (e == 7) busy7 = int'(BUSY);
      end
      START = 1'b0;
      check("hold_first_done", first_done, 5);
      check("hold_idle_gap_busy", busy6, 0);
      check("hold_restart_busy", busy7, 1);
      check("hold_second_done", second_done, 12);
      check("hold_result", int'(RESULT), 2);
      $display("start held -> done at k+%0d and k+%0d result=%0d",
               first_done, second_done, RESULT);
      repeat (3) @(posedge CLK);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
